dbank_dma: RTL and testbench
============================

DBANK_DMA -- requirements
Module: dbank_dma

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32: data word width, equal to the dbank external data width.
REQ-002 The block SHALL have parameter EXA_W, default 14: external address width, equal to the dbank exa width.
REQ-003 The block SHALL have parameter LEN_W, default 10: burst length field width.
REQ-004 Port clk, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 Ports i_req (1), i_dir (1; 0 = write to bank, 1 = read from bank), i_addr (EXA_W) and i_len (LEN_W, count of words) SHALL be inputs; o_ack SHALL be a 1-bit output: burst command.
REQ-007 Ports i_wvalid (1), i_wdata (DATA_W) and output o_wready (1) SHALL form the host write-data stream.
REQ-008 Outputs o_rvalid (1) and o_rdata (DATA_W), plus input i_rready (1), SHALL form the host read-data stream.
REQ-009 Outputs o_exa (EXA_W), o_exwd (DATA_W), o_exwe (1) and o_exre (1), plus input i_exrd (DATA_W), SHALL connect to the dbank external port.
REQ-010 Input i_swap_req (1) and outputs o_swap_ack (1) and o_cbank (1) SHALL implement bank swap toward the dbank bank select.
REQ-011 Outputs o_busy (1) and o_err (1) SHALL report status.

Function
REQ-012 The FSM SHALL have states IDLE, WR, RD, DRAIN and SWAP.
REQ-013 In IDLE, i_req with i_len != 0 SHALL produce a one-cycle o_ack pulse, latch the address and length, and move to WR if i_dir=0 or to RD if i_dir=1.
REQ-014 A request with i_len == 0 SHALL be acked with no bank access and the FSM SHALL remain in IDLE.
REQ-015 In WR, o_wready SHALL be 1; each cycle with i_wvalid=1 SHALL drive o_exwe=1, o_exwd=i_wdata and o_exa=current address, combinationally in the same cycle.
REQ-016 After each WR transfer, the address SHALL increment by 1 and the remaining count SHALL decrement by 1; the last transfer SHALL return the FSM to IDLE.
REQ-017 In RD, o_exre SHALL be asserted only when the 2-entry read buffer occupancy plus in-flight reads is less than 2.
REQ-018 i_exrd SHALL be captured into the read buffer exactly one cycle after o_exre.
REQ-019 o_rvalid SHALL equal buffer-not-empty, and o_rdata SHALL be the buffer head; the buffer SHALL pop on o_rvalid & i_rready.
REQ-020 After the last read is issued, the FSM SHALL enter DRAIN and return to IDLE when the buffer is empty and no read is in flight.
REQ-021 No read data SHALL be lost or duplicated under any i_rready pattern.
REQ-022 Throughput SHALL be 1 word per cycle when i_wvalid, or i_rready, is held high.
REQ-023 i_swap_req SHALL be honoured only in IDLE; if it arrives with i_req in the same cycle, the swap SHALL take priority and the request SHALL wait.
REQ-024 SWAP SHALL last one cycle: o_cbank toggles, o_swap_ack pulses for one cycle, then the FSM returns to IDLE.
REQ-025 o_exwe and o_exre SHALL never be asserted in the same cycle, nor in IDLE or SWAP.
REQ-026 o_busy SHALL be 1 in every state except IDLE.

Reset
REQ-027 rst_n low SHALL immediately force: FSM to IDLE, address and count to 0, read buffer empty, in-flight flag 0, o_cbank=0, and all valid, ack, enable and error outputs to 0.
REQ-028 Reset asserted mid-burst SHALL abort the burst; no bank access SHALL occur after reset deasserts until a new command is accepted.

Configuration
REQ-029 With macro DBANK_DMA_BOUND_EN defined, a request where i_addr + i_len > 2^EXA_W SHALL be acked, perform no access, and pulse o_err for one cycle.
REQ-030 Without DBANK_DMA_BOUND_EN, the address SHALL wrap modulo 2^EXA_W and o_err SHALL be constant 0.

Verification
REQ-031 Write burst: addr=0x010, len=4, i_wvalid held high, data A0..A3 -> o_exwe high on 4 consecutive cycles at o_exa 0x010..0x013, then IDLE.
REQ-032 Read burst with backpressure: addr=0x020, len=5, i_rready toggling 1,0,0,1 -> exactly 5 words delivered in order; o_exre never issued while occupancy plus in-flight equals 2.
REQ-033 Simultaneous i_swap_req and i_req in IDLE -> o_cbank 0->1 with one o_swap_ack pulse first; the burst is acked one cycle later.
REQ-034 Wrap: addr=2^EXA_W-2, len=4 -> with macro: o_err pulse and no access; without macro: addresses 3FFE, 3FFF, 0000, 0001.
REQ-035 rst_n pulled low on the 3rd word of an 8-word write -> all outputs 0 asynchronously; no o_exwe after release.

Source files
------------

// File: rtl/dbank_dma.sv
// dbank_dma: burst DMA between host streams and the dbank external port with bank swap; define DBANK_DMA_BOUND_EN to reject bursts that run past the top address
module dbank_dma #(
  parameter int DATA_W = 32,
  parameter int EXA_W  = 14,
  parameter int LEN_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic              i_dir,
  input  logic [EXA_W-1:0]  i_addr,
  input  logic [LEN_W-1:0]  i_len,
  output logic              o_ack,
  input  logic              i_wvalid,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_wready,
  output logic              o_rvalid,
  output logic [DATA_W-1:0] o_rdata,
  input  logic              i_rready,
  output logic [EXA_W-1:0]  o_exa,
  output logic [DATA_W-1:0] o_exwd,
  output logic              o_exwe,
  output logic              o_exre,
  input  logic [DATA_W-1:0] i_exrd,
  input  logic              i_swap_req,
  output logic              o_swap_ack,
  output logic              o_cbank,
  output logic              o_busy,
  output logic              o_err
);
  typedef enum logic [2:0] {IDLE, WR, RD, DRAIN, SWAP} state_t;
  state_t state, state_nx;
  logic [EXA_W-1:0] addr;
  logic [LEN_W-1:0] cnt;
  logic [DATA_W-1:0] buf_q [2];
  logic wp, rp, infl, cbank;
  logic [1:0] occ;
  logic start, oob, pop, issue, wr_xfer;
  assign start = rst_n && state == IDLE && i_req && !i_swap_req;
`ifdef DBANK_DMA_BOUND_EN
  localparam int SW = (EXA_W > LEN_W ? EXA_W : LEN_W) + 2;
  assign oob = (SW'(i_addr) + SW'(i_len)) > (SW'(1) << EXA_W);
`else
  assign oob = 1'b0;
`endif
  assign wr_xfer = state == WR && i_wvalid;
  assign o_rvalid = occ != 2'd0;
  assign pop = o_rvalid && i_rready;
  // a slot popped this cycle is free for the word requested now, keeping reads at one per cycle
  assign issue = state == RD && (3'(occ) - 3'(pop) + 3'(infl)) < 3'd2;
  assign o_ack = start;
  assign o_err = start && oob;
  assign o_wready = state == WR;
  assign o_exwe = wr_xfer;
  assign o_exre = issue;
  assign o_exa = addr;
  assign o_exwd = wr_xfer ? i_wdata : '0;
  assign o_rdata = buf_q[rp];
  assign o_swap_ack = state == SWAP;
  assign o_cbank = cbank;
  assign o_busy = state != IDLE;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = i_swap_req ? SWAP : (start && i_len != '0 && !oob) ? (i_dir ? RD : WR) : IDLE;
      WR:      state_nx = (wr_xfer && cnt == LEN_W'(1)) ? IDLE : WR;
      RD:      state_nx = (issue && cnt == LEN_W'(1)) ? DRAIN : RD;
      DRAIN:   state_nx = (occ == 2'd0 && !infl) ? IDLE : DRAIN;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      addr <= '0;
      cnt <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      occ <= 2'd0;
      infl <= 1'b0;
      cbank <= 1'b0;
    end else begin
      state <= state_nx;
      if (start) begin
        addr <= i_addr;
        cnt <= i_len;
      end else if (wr_xfer || issue) begin
        addr <= addr + EXA_W'(1);
        cnt <= cnt - LEN_W'(1);
      end
      infl <= issue;
      if (infl) wp <= ~wp;
      if (pop) rp <= ~rp;
      occ <= occ + {1'b0, infl} - {1'b0, pop};
      if (state == IDLE && i_swap_req) cbank <= ~cbank;
    end
  end
  always_ff @(posedge clk)
    if (infl) buf_q[wp] <= i_exrd;
endmodule

// File: tb/tb_dbank_dma.sv
// tb_dbank_dma: random and directed bursts against a queue/array model of the host and bank traffic
module tb_dbank_dma;
  localparam int DATA_W = 32, EXA_W = 14, LEN_W = 10, TOP = 1 << EXA_W;
`ifdef DBANK_DMA_BOUND_EN
  localparam bit BOUND = 1'b1;
`else
  localparam bit BOUND = 1'b0;
`endif
  logic clk = 0, rst_n = 0;
  logic i_req = 0, i_dir = 0, i_wvalid = 0, i_rready = 0, i_swap_req = 0;
  logic [EXA_W-1:0] i_addr = '0;
  logic [LEN_W-1:0] i_len = '0;
  logic [DATA_W-1:0] i_wdata = '0, i_exrd = '0;
  logic o_ack, o_wready, o_rvalid, o_exwe, o_exre, o_swap_ack, o_cbank, o_busy, o_err;
  logic [DATA_W-1:0] o_rdata, o_exwd;
  logic [EXA_W-1:0] o_exa;

  dbank_dma #(.DATA_W(DATA_W), .EXA_W(EXA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .i_req(i_req), .i_dir(i_dir), .i_addr(i_addr), .i_len(i_len),
    .o_ack(o_ack), .i_wvalid(i_wvalid), .i_wdata(i_wdata), .o_wready(o_wready),
    .o_rvalid(o_rvalid), .o_rdata(o_rdata), .i_rready(i_rready), .o_exa(o_exa),
    .o_exwd(o_exwd), .o_exwe(o_exwe), .o_exre(o_exre), .i_exrd(i_exrd),
    .i_swap_req(i_swap_req), .o_swap_ack(o_swap_ack), .o_cbank(o_cbank),
    .o_busy(o_busy), .o_err(o_err)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] bank [2][TOP];
  logic [DATA_W-1:0] ref_mem [2][TOP];
  always @(posedge clk) begin
    if (o_exwe) bank[o_cbank][o_exa] <= o_exwd;
    if (o_exre) i_exrd <= bank[o_cbank][o_exa];
  end

  int n_chk = 0, n_err = 0, cyc = 0;
  int wr_left = 0, rd_left = 0, outst = 0, popped = 0, swaps = 0, errs = 0, exwe_cnt = 0;
  bit issued_prev = 0, m_cbank = 0, pop, m_busy, oob;
  logic [EXA_W-1:0] wr_addr = '0, rd_addr = '0, ma;
  logic [DATA_W-1:0] exp_rq[$], rd_log[$];
  logic [EXA_W-1:0] wr_log[$];
  int wr_cyc[$], pop_cyc[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit oob_f(input int a, input int len);
    return BOUND && (a + len > TOP);
  endfunction

  // reference model: host-level bookkeeping of burst words, outstanding reads and bank contents
  always @(negedge clk) begin
    if (!rst_n) begin
      wr_left = 0; rd_left = 0; outst = 0; issued_prev = 0; m_cbank = 0;
      exp_rq.delete();
    end else begin
      m_busy = wr_left > 0 || rd_left > 0 || outst > 0;
      pop = o_rvalid && i_rready;
      if (o_exwe) exwe_cnt++;
      chk("exclusive", o_exwe && o_exre, 0);
      chk("wready", o_wready, wr_left > 0);
      chk("exwe", o_exwe, wr_left > 0 && i_wvalid);
      if (o_exwe && wr_left > 0) begin
        chk("wr_addr", o_exa, wr_addr);
        chk("wr_data", o_exwd, i_wdata);
        ref_mem[m_cbank][wr_addr] = i_wdata;
        wr_log.push_back(o_exa);
        wr_cyc.push_back(cyc);
        wr_addr++; wr_left--;
      end
      chk("rvalid", o_rvalid, (outst - int'(issued_prev)) > 0);
      if (pop) begin
        if (exp_rq.size() == 0) chk("rd_extra", 1, 0);
        else chk("rd_data", o_rdata, exp_rq.pop_front());
        rd_log.push_back(o_rdata);
        pop_cyc.push_back(cyc);
        if (outst > 0) outst--;
        popped++;
      end
      issued_prev = o_exre;
      if (o_exre) begin
        chk("exre_legal", rd_left > 0, 1);
        chk("exre_room", outst < 2, 1);
        chk("rd_addr", o_exa, rd_addr);
        rd_addr++;
        if (rd_left > 0) rd_left--;
        outst++;
      end
      oob = oob_f(int'(i_addr), int'(i_len));
      chk("err", o_err, o_ack && oob);
      if (o_err) errs++;
      if (o_ack) begin
        chk("ack_idle", m_busy, 0);
        chk("ack_req", i_req && !i_swap_req, 1);
        if (i_len != 0 && !oob) begin
          if (!i_dir) begin
            wr_left = int'(i_len); wr_addr = i_addr;
          end else begin
            rd_left = int'(i_len); rd_addr = i_addr; ma = i_addr;
            for (int i = 0; i < int'(i_len); i++) begin
              exp_rq.push_back(ref_mem[m_cbank][ma]);
              ma++;
            end
          end
        end
      end
      if (o_swap_ack) begin
        chk("swap_idle", m_busy, 0);
        m_cbank = !m_cbank;
        swaps++;
      end
      chk("cbank", o_cbank, m_cbank);
      if (m_busy) chk("busy", o_busy, 1);
    end
  end

  task automatic cmd(input logic dir, input logic [EXA_W-1:0] a, input int len, output bit ok);
    i_req = 1; i_dir = dir; i_addr = a; i_len = LEN_W'(len);
    ok = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk); ok = o_ack;
      @(posedge clk); #1;
    end
    i_req = 0;
    chk("ack_seen", ok, 1);
  endtask

  task automatic wr_data(input bit full, input bit seq, input logic [DATA_W-1:0] base);
    for (int k = 0; k < 2000 && wr_left > 0; k++) begin
      i_wvalid = full || 1'($urandom_range(0, 1));
      i_wdata = seq ? base + DATA_W'(wr_log.size()) : $urandom;
      @(posedge clk); #1;
    end
    i_wvalid = 0;
    chk("wr_done", wr_left, 0);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 50 && o_busy; k++) begin @(posedge clk); #1; end
    chk("idle", o_busy, 0);
  endtask

  task automatic rd_burst(input logic [EXA_W-1:0] a, input int len, input int mode);
    bit ok;
    int p0;
    p0 = popped;
    cmd(1, a, len, ok);
    for (int k = 0; k < 3000 && (rd_left > 0 || outst > 0); k++) begin
      i_rready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) : (k % 4 == 0 || k % 4 == 3);
      @(posedge clk); #1;
    end
    i_rready = 0;
    chk("rd_count", popped - p0, (ok && !oob_f(int'(a), len)) ? len : 0);
    wait_idle();
  endtask

  task automatic do_swap();
    int s0;
    s0 = swaps;
    i_swap_req = 1;
    @(posedge clk); #1;
    i_swap_req = 0;
    for (int k = 0; k < 5 && swaps == s0; k++) begin @(posedge clk); #1; end
    chk("swap_seen", swaps - s0, 1);
  endtask

  initial begin
    bit ok;
    int op, len, n0;
    logic [EXA_W-1:0] a;
    logic [EXA_W-1:0] wexp [4];
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < TOP; i++) begin bank[b][i] = '0; ref_mem[b][i] = '0; end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", o_busy, 0); chk("rst_ack", o_ack, 0); chk("rst_rvalid", o_rvalid, 0);
    chk("rst_exwe", o_exwe, 0); chk("rst_exre", o_exre, 0); chk("rst_cbank", o_cbank, 0);
    chk("rst_swap_ack", o_swap_ack, 0); chk("rst_err", o_err, 0);
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;

    // swap and request together: swap first, burst acked one cycle after the swap ack
    i_swap_req = 1; i_req = 1; i_dir = 0; i_addr = 14'h100; i_len = 10'd2;
    @(negedge clk);
    chk("sw_ack0", o_ack, 0); chk("sw_sack0", o_swap_ack, 0); chk("sw_cb0", o_cbank, 0);
    @(posedge clk); #1 i_swap_req = 0;
    @(negedge clk);
    chk("sw_sack1", o_swap_ack, 1); chk("sw_cb1", o_cbank, 1); chk("sw_ack1", o_ack, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("sw_ack2", o_ack, 1); chk("sw_sack2", o_swap_ack, 0);
    @(posedge clk); #1 i_req = 0;
    wr_data(1, 0, 0);

    // write A0..A3 to 0x010 back to back, then read them back
    wr_log.delete(); wr_cyc.delete();
    cmd(0, 14'h010, 4, ok);
    wr_data(1, 1, 32'hA0);
    chk("w31_n", wr_log.size(), 4);
    for (int i = 0; i < 4 && i < wr_log.size(); i++) chk("w31_addr", wr_log[i], 14'h010 + 14'(i));
    if (wr_cyc.size() == 4) chk("w31_span", wr_cyc[3] - wr_cyc[0], 3);
    wait_idle();
    rd_log.delete(); pop_cyc.delete();
    rd_burst(14'h010, 4, 0);
    chk("r31_n", rd_log.size(), 4);
    for (int i = 0; i < 4 && i < rd_log.size(); i++) chk("r31_data", rd_log[i], 32'hA0 + 32'(i));

    // read with 1,0,0,1 backpressure
    cmd(0, 14'h020, 5, ok); wr_data(1, 0, 0); wait_idle();
    rd_burst(14'h020, 5, 2);

    // full-rate read
    cmd(0, 14'h040, 8, ok); wr_data(1, 1, 32'h5000); wait_idle();
    pop_cyc.delete();
    rd_burst(14'h040, 8, 0);
    chk("thru_n", pop_cyc.size(), 8);
    if (pop_cyc.size() == 8) chk("thru_span", pop_cyc[7] - pop_cyc[0], 7);

    // zero-length request
    n0 = exwe_cnt;
    cmd(0, 14'h055, 0, ok);
    chk("zl_idle", o_busy, 0);
    chk("zl_noacc", exwe_cnt - n0, 0);

    // burst crossing the top of the address space
    wr_log.delete();
    n0 = errs;
    cmd(0, 14'(TOP - 2), 4, ok);
    wr_data(1, 0, 0);
    wexp[0] = 14'h3FFE; wexp[1] = 14'h3FFF; wexp[2] = 14'h0000; wexp[3] = 14'h0001;
`ifdef DBANK_DMA_BOUND_EN
    chk("wrap_noacc", wr_log.size(), 0);
    chk("wrap_err", errs - n0, 1);
`else
    chk("wrap_n", wr_log.size(), 4);
    for (int i = 0; i < 4 && i < wr_log.size(); i++) chk("wrap_addr", wr_log[i], wexp[i]);
    chk("wrap_noerr", errs - n0, 0);
`endif
    wait_idle();

    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 9);
      len = $urandom_range(1, 12);
      a = $urandom_range(0, 1) ? 14'(14'h300 + $urandom_range(0, 31)) : 14'(TOP - 8 + $urandom_range(0, 7));
      if (op < 4) begin
        cmd(0, a, len, ok); wr_data(1'($urandom_range(0, 1)), 0, 0); wait_idle();
      end else if (op < 8) rd_burst(a, len, $urandom_range(0, 1));
      else if (op == 8) do_swap();
      else cmd(1'($urandom_range(0, 1)), a, 0, ok);
    end

    // reset during the third word of an 8-word write
    if (!o_cbank) do_swap();
    cmd(0, 14'h200, 8, ok);
    i_wvalid = 1;
    for (int k = 0; k < 20 && wr_left > 6; k++) begin i_wdata = $urandom; @(posedge clk); #1; end
    #1 rst_n = 0;
    #1;
    chk("ar_exwe", o_exwe, 0); chk("ar_wready", o_wready, 0); chk("ar_busy", o_busy, 0);
    chk("ar_ack", o_ack, 0); chk("ar_exre", o_exre, 0); chk("ar_rvalid", o_rvalid, 0);
    chk("ar_cbank", o_cbank, 0); chk("ar_sack", o_swap_ack, 0); chk("ar_err", o_err, 0);
    @(posedge clk); #1 rst_n = 1;
    n0 = exwe_cnt;
    repeat (5) begin @(posedge clk); #1; end
    i_wvalid = 0;
    chk("ar_noexwe", exwe_cnt - n0, 0);
    cmd(0, 14'h210, 3, ok); wr_data(0, 0, 0); wait_idle();
    rd_burst(14'h210, 3, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
